ysyx_23060203_mem_resp: RTL and testbench
=========================================

// Module: ysyx_23060203_mem_resp
// PURPOSE
//  Data-memory responder: the memory-side end of the EXU load/store interface.
//  - Accepts one load or store request at a time over a valid/ready handshake.
//  - Decodes RV32 funct width and sign, applies byte-lane strobes, serves a word-organised SRAM array.
//  - Returns read data or a write ack after a programmable latency; stands in for the DPI memory model.
// PARAMETERS
//  BASE_ADDR    32'h8000_0000  byte address of word 0
//  DEPTH_WORDS  1024           array size in 32-bit words (power of two)
//  LATENCY      2              cycles from request accept to rsp_valid (legal range 1..15)
// PORTS
//  clk        in   1   clock, rising edge
//  rst_n      in   1   asynchronous, active-low reset
//  req_valid  in   1   request present
//  req_ready  out  1   responder can accept a request
//  req_wen    in   1   1 = store, 0 = load
//  req_func   in   3   funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU (stores: 000/001/010 only)
//  req_addr   in   32  byte address
//  req_wdata  in   32  store data, LSB-aligned (byte/half taken from bits [7:0]/[15:0])
//  rsp_valid  out  1   response present
//  rsp_ready  in   1   consumer takes response
//  rsp_rdata  out  32  load result, sign/zero extended; 0 for stores and errors
//  rsp_err    out  1   misaligned, out-of-range or illegal funct
// BEHAVIOUR
//  - Reset (async assert, sync release):
//    - state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0.
//    - Array contents are not reset.
//  - FSM states IDLE, WAIT, RESP:
//    - IDLE: req_ready=1. On req_valid, latch wen/func/addr/wdata, load counter=LATENCY-1, go to WAIT.
//    - WAIT: req_ready=0. Counter decrements each cycle. When counter==0:
//      - commit a legal store to the array;
//      - register rdata/err;
//      - go to RESP.
//      With LATENCY=1, WAIT lasts exactly one cycle.
//    - RESP: rsp_valid=1. rsp_rdata and rsp_err are held stable until rsp_ready=1. Then go to IDLE.
//  - Latency: request accepted at edge N gives rsp_valid high from edge N+LATENCY.
//    - One idle bubble (IDLE) between consecutive requests; never more than one outstanding request.
//  - Address decode:
//    - off = addr - BASE_ADDR (32-bit wrap);
//    - in range iff off < DEPTH_WORDS*4;
//    - word index = off[log2(DEPTH_WORDS)+1:2]; byte lane = off[1:0].
//  - Error conditions (rsp_err=1, rsp_rdata=0, no array write):
//    - H/HU with lane[0]!=0;
//    - W with lane!=0;
//    - out of range;
//    - funct 011/110/111;
//    - store funct 100/101.
//  - Load extract: byte/half selected by lane, then sign-extended (B, H) or zero-extended (BU, HU).
//  - Store strobe: SB writes 1 lane, SH writes 2 lanes, SW writes 4 lanes.
//    - Only strobed bytes change. The write happens in the single WAIT→RESP cycle.
//  - Stores also produce a response (ack) with rsp_rdata=0.
//  - Request inputs are sampled only at accept; changes after accept are ignored.
//  - Reset mid-operation: any pending store in WAIT is dropped (not committed); any response in RESP is discarded.
//  - rsp_ready outside RESP is ignored. req_valid outside IDLE is not accepted.
// STRUCTURE
//  - Package ysyx_23060203_mem_pkg holds:
//    - funct constants (MF_B, MF_H, MF_W, MF_BU, MF_HU);
//    - state enum (IDLE/WAIT/RESP);
//    - function lane_err(func, lane).
//  - Sub-module ysyx_23060203_mem_lane (combinational) contains:
//    - from func/lane/wdata: 4-bit strobe and aligned write word;
//    - from func/lane/rdata: extended load value.
//  - Top level holds the FSM, latency counter, request latches and the array.
// TESTING
//  - Reset mid-WAIT: SW 0x8000_0010 := 0x1234_5678, assert rst_n=0 in WAIT, release, LW 0x8000_0010
//    -> old contents returned, outputs were 0/req_ready=1 during reset.
//  - Word round trip: SW 0x8000_0000 := 0xDEAD_BEEF, then LW 0x8000_0000
//    -> rdata 0xDEAD_BEEF, err=0, rsp_valid exactly LATENCY cycles after accept.
//  - Sign extension: after the write above:
//    - LB 0x8000_0003 -> 0xFFFF_FFDE;
//    - LBU 0x8000_0003 -> 0x0000_00DE;
//    - LH 0x8000_0000 -> 0xFFFF_BEEF;
//    - LHU 0x8000_0002 -> 0x0000_DEAD.
//  - Strobes: SB 0x8000_0001 := 0xAA, then SH 0x8000_0002 := 0x1122, then LW 0x8000_0000 -> 0x1122_AAEF.
//  - Errors:
//    - LW 0x8000_0002 -> err=1, rdata 0;
//    - SH 0x8000_0001 -> err=1, memory unchanged;
//    - LW 0x8000_1000 (DEPTH=1024) -> err=1;
//    - funct 011 -> err=1.
//  - Backpressure: hold rsp_ready=0 for 5 cycles in RESP
//    -> rsp_valid/rdata stable, req_ready=0; set rsp_ready=1 -> IDLE next cycle.
//    Repeat with LATENCY=1.

Source files
------------

// File: rtl/ysyx_23060203_mem_pkg.sv
// Shared types and helpers for the data-memory responder.
// Holds the funct3 width codes, the FSM state type, the latched request payload and the alignment check.
package ysyx_23060203_mem_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned FUNC_W = 3;
    localparam int unsigned LANE_W = 2;
    localparam int unsigned STRB_W = 4;
    localparam int unsigned CNT_W  = 4;

    localparam logic [FUNC_W-1:0] MF_B  = 3'b000;
    localparam logic [FUNC_W-1:0] MF_H  = 3'b001;
    localparam logic [FUNC_W-1:0] MF_W  = 3'b010;
    localparam logic [FUNC_W-1:0] MF_BU = 3'b100;
    localparam logic [FUNC_W-1:0] MF_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_e;

    typedef struct packed {
        logic              wen;
        logic [FUNC_W-1:0] func;
        logic [WORD_W-1:0] addr;
        logic [WORD_W-1:0] wdata;
    } mem_req_t;

    // Misalignment for the access width, or an unknown funct3 code.
    function automatic logic lane_err(input logic [FUNC_W-1:0] func, input logic [LANE_W-1:0] lane);
        logic r;
        case (func)
            MF_B, MF_BU: r = 1'b0;
            MF_H, MF_HU: r = lane[0];
            MF_W:        r = (lane != 2'b00);
            default:     r = 1'b1;
        endcase
        lane_err = r;
    endfunction

endpackage

// File: rtl/ysyx_23060203_mem_lane.sv
// Byte-lane steering: store strobe/aligned write word and load extract/extension.
module ysyx_23060203_mem_lane
    import ysyx_23060203_mem_pkg::*;
(
    input  logic [FUNC_W-1:0] i_func,
    input  logic [LANE_W-1:0] i_lane,
    input  logic [WORD_W-1:0] i_wdata,
    input  logic [WORD_W-1:0] i_rdata,
    output logic [STRB_W-1:0] o_strb,
    output logic [WORD_W-1:0] o_wword,
    output logic [WORD_W-1:0] o_ldata
);

    logic [15:0] w_half;
    logic [7:0]  w_byte;

    assign w_half = i_lane[1] ? i_rdata[31:16] : i_rdata[15:0];
    assign w_byte = i_lane[0] ? w_half[15:8] : w_half[7:0];

    always_comb begin
        o_strb  = '0;
        o_wword = i_wdata;
        o_ldata = '0;
        case (i_func)
            MF_B: begin
                o_strb  = STRB_W'(4'b0001 << i_lane);
                o_wword = {4{i_wdata[7:0]}};
                o_ldata = {{24{w_byte[7]}}, w_byte};
            end
            MF_BU: o_ldata = {24'd0, w_byte};
            MF_H: begin
                o_strb  = i_lane[1] ? 4'b1100 : 4'b0011;
                o_wword = {2{i_wdata[15:0]}};
                o_ldata = {{16{w_half[15]}}, w_half};
            end
            MF_HU: o_ldata = {16'd0, w_half};
            MF_W: begin
                o_strb  = 4'b1111;
                o_wword = i_wdata;
                o_ldata = i_rdata;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ysyx_23060203_mem_resp.sv
// Data-memory responder: one outstanding load/store, fixed latency, word-organised SRAM model.
module ysyx_23060203_mem_resp
    import ysyx_23060203_mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [FUNC_W-1:0] req_func,
    input  logic [WORD_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

    mem_state_e        r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    mem_req_t          r_req, w_req_nxt;
    logic [WORD_W-1:0] r_rdata, w_rdata_nxt;
    logic              r_err, w_err_nxt;
    logic              r_req_ready, w_req_ready_nxt;
    logic              r_rsp_valid, w_rsp_valid_nxt;
    logic              w_commit;

    logic [WORD_W-1:0] r_mem [DEPTH_WORDS];

    logic [WORD_W-1:0] w_off;
    logic              w_in_range;
    logic [IDX_W-1:0]  w_idx;
    logic [LANE_W-1:0] w_lane;
    logic              w_bad;
    logic [STRB_W-1:0] w_strb;
    logic [WORD_W-1:0] w_wword;
    logic [WORD_W-1:0] w_ldata;

    // Decode of the latched request.
    assign w_off      = r_req.addr - BASE_ADDR;
    assign w_in_range = (w_off < WORD_W'(DEPTH_WORDS * 4));
    assign w_idx      = w_off[IDX_W+1:2];
    assign w_lane     = w_off[1:0];
    assign w_bad      = !w_in_range || lane_err(r_req.func, w_lane)
                        || (r_req.wen && (r_req.func == MF_BU || r_req.func == MF_HU));

    ysyx_23060203_mem_lane u_lane (
        .i_func  (r_req.func),
        .i_lane  (w_lane),
        .i_wdata (r_req.wdata),
        .i_rdata (r_mem[w_idx]),
        .o_strb  (w_strb),
        .o_wword (w_wword),
        .o_ldata (w_ldata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_req       <= '0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_req       <= w_req_nxt;
            r_rdata     <= w_rdata_nxt;
            r_err       <= w_err_nxt;
            r_req_ready <= w_req_ready_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_req_nxt       = r_req;
        w_rdata_nxt     = r_rdata;
        w_err_nxt       = r_err;
        w_req_ready_nxt = r_req_ready;
        w_rsp_valid_nxt = r_rsp_valid;
        w_commit        = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_req_nxt       = '{wen: req_wen, func: req_func, addr: req_addr, wdata: req_wdata};
                    w_cnt_nxt       = CNT_W'(LATENCY - 1);
                    w_req_ready_nxt = 1'b0;
                    w_state_nxt     = WAIT;
                end
            end
            WAIT: begin
                if (r_cnt == '0) begin
                    w_commit        = r_req.wen && !w_bad;
                    w_rdata_nxt     = (r_req.wen || w_bad) ? '0 : w_ldata;
                    w_err_nxt       = w_bad;
                    w_rsp_valid_nxt = 1'b1;
                    w_state_nxt     = RESP;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_rsp_valid_nxt = 1'b0;
                    w_req_ready_nxt = 1'b1;
                    w_state_nxt     = IDLE;
                end
            end
            default: begin
                w_req_ready_nxt = 1'b1;
                w_rsp_valid_nxt = 1'b0;
                w_state_nxt     = IDLE;
            end
        endcase
    end

    // Strobed store; contents intentionally have no reset.
    always_ff @(posedge clk) begin
        if (w_commit) begin
            for (int b = 0; b < int'(STRB_W); b++) begin
                if (w_strb[b]) r_mem[w_idx][8*b +: 8] <= w_wword[8*b +: 8];
            end
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

endmodule

// File: tb/tb_ysyx_23060203_mem_resp.sv
// Directed bench for ysyx_23060203_mem_resp: one instance at LATENCY=2, one at LATENCY=1.
module tb_ysyx_23060203_mem_resp;

    localparam int unsigned LAT0 = 2;
    localparam int unsigned LAT1 = 1;
    localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010, F_BU = 3'b100, F_HU = 3'b101;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_wen   [2];
    logic [2:0]  req_func  [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ysyx_23060203_mem_resp #(.LATENCY(LAT0)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_wen(req_wen[0]),
        .req_func(req_func[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    ysyx_23060203_mem_resp #(.LATENCY(LAT1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_wen(req_wen[1]),
        .req_func(req_func[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one request starting at a negedge; returns at a negedge with the responder idle.
    task automatic do_req(input int s, input logic wen, input logic [2:0] func,
                          input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                          output logic [31:0] rdata, output logic err, output int lat);
        check_eq("req_ready_idle", 32'(req_ready[s]), 32'd1);
        req_valid[s] = 1'b1;
        req_wen[s]   = wen;
        req_func[s]  = func;
        req_addr[s]  = addr;
        req_wdata[s] = wdata;
        @(posedge clk); #1;
        req_valid[s] = 1'b0;
        req_wen[s]   = ~wen;
        req_func[s]  = 3'b111;
        req_addr[s]  = 32'hFFFF_FFFF;
        req_wdata[s] = ~wdata;
        lat   = 0;
        rdata = '0;
        err   = 1'b1;
        while (lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (rsp_valid[s]) break;
        end
        if (!rsp_valid[s]) begin
            check_eq("rsp_timeout", 32'(rsp_valid[s]), 32'd1);
            @(negedge clk);
            return;
        end
        rdata = rsp_rdata[s];
        err   = rsp_err[s];
        check_eq("req_ready_resp", 32'(req_ready[s]), 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check_eq("bp_valid", 32'(rsp_valid[s]), 32'd1);
            check_eq("bp_rdata", rsp_rdata[s], rdata);
            check_eq("bp_err", 32'(rsp_err[s]), 32'(err));
            check_eq("bp_req_ready", 32'(req_ready[s]), 32'd0);
        end
        rsp_ready[s] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[s] = 1'b0;
        check_eq("rsp_valid_drop", 32'(rsp_valid[s]), 32'd0);
        check_eq("req_ready_back", 32'(req_ready[s]), 32'd1);
        @(negedge clk);
    endtask

    task automatic xact(input string tag, input int s, input logic wen, input logic [2:0] func,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err, input int hold);
        logic [31:0] rd;
        logic        er;
        int          lat;
        do_req(s, wen, func, addr, wdata, hold, rd, er, lat);
        check_eq({tag, "_rdata"}, rd, exp_rdata);
        check_eq({tag, "_err"}, 32'(er), 32'(exp_err));
        check_eq({tag, "_lat"}, 32'(lat), (s == 0) ? 32'(LAT0) : 32'(LAT1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int s = 0; s < 2; s++) begin
            req_valid[s] = 1'b0; req_wen[s] = 1'b0; req_func[s] = '0;
            req_addr[s] = '0; req_wdata[s] = '0; rsp_ready[s] = 1'b0;
        end
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            check_eq("rst_req_ready", 32'(req_ready[s]), 32'd1);
            check_eq("rst_rsp_valid", 32'(rsp_valid[s]), 32'd0);
            check_eq("rst_rsp_rdata", rsp_rdata[s], 32'd0);
            check_eq("rst_rsp_err", 32'(rsp_err[s]), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // Store dropped by a reset that lands in WAIT.
        xact("sw_old", 0, 1'b1, F_W, 32'h8000_0010, 32'hCAFE_F00D, 32'h0, 1'b0, 0);
        req_valid[0] = 1'b1; req_wen[0] = 1'b1; req_func[0] = F_W;
        req_addr[0] = 32'h8000_0010; req_wdata[0] = 32'h1234_5678;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        check_eq("wait_req_ready", 32'(req_ready[0]), 32'd0);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_req_ready", 32'(req_ready[0]), 32'd1);
        check_eq("midrst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
        check_eq("midrst_rsp_rdata", rsp_rdata[0], 32'd0);
        check_eq("midrst_rsp_err", 32'(rsp_err[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        xact("lw_after_rst", 0, 1'b0, F_W, 32'h8000_0010, 32'h0, 32'hCAFE_F00D, 1'b0, 0);

        xact("sw_word", 0, 1'b1, F_W, 32'h8000_0000, 32'hDEAD_BEEF, 32'h0, 1'b0, 0);
        xact("lw_word", 0, 1'b0, F_W, 32'h8000_0000, 32'h0, 32'hDEAD_BEEF, 1'b0, 0);
        xact("lb3", 0, 1'b0, F_B, 32'h8000_0003, 32'h0, 32'hFFFF_FFDE, 1'b0, 0);
        xact("lbu3", 0, 1'b0, F_BU, 32'h8000_0003, 32'h0, 32'h0000_00DE, 1'b0, 0);
        xact("lh0", 0, 1'b0, F_H, 32'h8000_0000, 32'h0, 32'hFFFF_BEEF, 1'b0, 0);
        xact("lhu2", 0, 1'b0, F_HU, 32'h8000_0002, 32'h0, 32'h0000_DEAD, 1'b0, 0);

        xact("sb1", 0, 1'b1, F_B, 32'h8000_0001, 32'hFFFF_FFAA, 32'h0, 1'b0, 0);
        xact("sh2", 0, 1'b1, F_H, 32'h8000_0002, 32'hFFFF_1122, 32'h0, 1'b0, 0);
        xact("lw_strb", 0, 1'b0, F_W, 32'h8000_0000, 32'h0, 32'h1122_AAEF, 1'b0, 0);

        xact("lw_mis", 0, 1'b0, F_W, 32'h8000_0002, 32'h0, 32'h0, 1'b1, 0);
        xact("sh_mis", 0, 1'b1, F_H, 32'h8000_0001, 32'h0000_5566, 32'h0, 1'b1, 0);
        xact("sbu_ill", 0, 1'b1, F_BU, 32'h8000_0000, 32'h0000_0077, 32'h0, 1'b1, 0);
        xact("lw_unchg", 0, 1'b0, F_W, 32'h8000_0000, 32'h0, 32'h1122_AAEF, 1'b0, 0);
        xact("lw_oor", 0, 1'b0, F_W, 32'h8000_1000, 32'h0, 32'h0, 1'b1, 0);
        xact("lw_below", 0, 1'b0, F_W, 32'h7FFF_FFFC, 32'h0, 32'h0, 1'b1, 0);
        xact("f011", 0, 1'b0, 3'b011, 32'h8000_0000, 32'h0, 32'h0, 1'b1, 0);
        xact("sw_last", 0, 1'b1, F_W, 32'h8000_0FFC, 32'h0BAD_F00D, 32'h0, 1'b0, 0);
        xact("lw_last", 0, 1'b0, F_W, 32'h8000_0FFC, 32'h0, 32'h0BAD_F00D, 1'b0, 5);

        // LATENCY=1 instance, including backpressure in RESP.
        xact("l1_sw", 1, 1'b1, F_W, 32'h8000_0020, 32'h5566_7788, 32'h0, 1'b0, 0);
        xact("l1_lw_bp", 1, 1'b0, F_W, 32'h8000_0020, 32'h0, 32'h5566_7788, 1'b0, 5);
        xact("l1_lb1", 1, 1'b0, F_B, 32'h8000_0021, 32'h0, 32'h0000_0077, 1'b0, 0);
        xact("l1_lh2", 1, 1'b0, F_H, 32'h8000_0022, 32'h0, 32'h0000_5566, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
